// File: rtl/coco_regcap_pkg.sv
// CoCo register-capture FIFO shared types and constants.
// Entry layout is {addr[3:0], data[7:0]}; REGCAP_DEPTH is the default FIFO depth.
package coco_regcap_pkg;

    localparam int ENTRY_W      = 12;
    localparam int ADDR_LSB     = 8;
    localparam int DATA_LSB     = 0;
    localparam int REGCAP_DEPTH = 4;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/coco_pulse_sync.sv
// Two-flop synchronizer plus rising-edge detector for asynchronous AVR levels.
// Ports: eclk, reset_n (sync, active low), i_async level in, o_rise one-cycle pulse out.
module coco_pulse_sync (
    input  logic eclk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge eclk) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/coco_regcap_fifo.sv
// Captures CoCo writes to the SCS register window into a FIFO drained by the AVR.
// Ports: eclk/reset_n; CoCo bus (c_power, scs_n, c_rw, c_addr, c_data, a_busmaster);
// AVR side (a_pop, a_clr_ovf in; a_reg_addr, a_reg_data, a_empty, a_full, a_regint,
// a_ovf, halt_req out). Macro COCO_REGCAP_HALT_EN enables the almost-full halt_req.
module coco_regcap_fifo
    import coco_regcap_pkg::*;
#(
    parameter int DEPTH = REGCAP_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic       eclk,
    input  logic       reset_n,
    input  logic       c_power,
    input  logic       scs_n,
    input  logic       c_rw,
    input  logic [3:0] c_addr,
    input  logic [7:0] c_data,
    input  logic       a_busmaster,
    input  logic       a_pop,
    input  logic       a_clr_ovf,
    output logic [3:0] a_reg_addr,
    output logic [7:0] a_reg_data,
    output logic       a_empty,
    output logic       a_full,
    output logic       a_regint,
    output logic       a_ovf,
    output logic       halt_req
);

    localparam logic [PTR_W:0]   C_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   C_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] P_ONE  = PTR_W'(1);

    entry_t           r_mem [DEPTH];
    entry_t           r_head;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_ovf;

    logic             w_pop_rise;
    logic             w_clr_rise;
    logic             w_push;
    logic             w_pop;
    logic             w_acc;
    logic             w_drop;
    logic             w_nonempty;
    logic             w_is_full;
    logic [PTR_W-1:0] w_rd_inc;
    logic [PTR_W:0]   w_count_nx;
    entry_t           w_entry;
    entry_t           w_head_nx;

    coco_pulse_sync u_pop_sync (
        .eclk    (eclk),
        .reset_n (reset_n),
        .i_async (a_pop),
        .o_rise  (w_pop_rise)
    );

    coco_pulse_sync u_clr_sync (
        .eclk    (eclk),
        .reset_n (reset_n),
        .i_async (a_clr_ovf),
        .o_rise  (w_clr_rise)
    );

    assign w_push     = ~scs_n & ~c_rw & c_power & ~a_busmaster;
    assign w_nonempty = (r_count != '0);
    assign w_is_full  = (r_count == C_FULL);
    assign w_pop      = w_pop_rise & w_nonempty;
    // A pop frees the slot, so a push at full is still accepted.
    assign w_acc      = w_push & (~w_is_full | w_pop);
    assign w_drop     = w_push & w_is_full & ~w_pop;
    assign w_rd_inc   = r_rd_ptr + P_ONE;
    assign w_entry    = '{addr: c_addr, data: c_data};

    always_comb begin
        w_count_nx = r_count;
        case ({w_acc, w_pop})
            2'b10:   w_count_nx = r_count + C_ONE;
            2'b01:   w_count_nx = r_count - C_ONE;
            default: w_count_nx = r_count;
        endcase
    end

    // Head register tracks the next-state head so it lands with the flags.
    // Popping the last entry while pushing forwards the incoming entry.
    always_comb begin
        w_head_nx = r_head;
        if (w_pop) begin
            if (r_count == C_ONE) begin
                if (w_acc) begin
                    w_head_nx = w_entry;
                end
            end else begin
                w_head_nx = r_mem[w_rd_inc];
            end
        end else if (w_acc && !w_nonempty) begin
            w_head_nx = w_entry;
        end
    end

    always_ff @(posedge eclk) begin
        if (w_acc) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge eclk) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_acc) begin
                r_wr_ptr <= r_wr_ptr + P_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_inc;
            end
            r_count <= w_count_nx;
            r_head  <= w_head_nx;
            r_empty <= (w_count_nx == '0);
            r_full  <= (w_count_nx == C_FULL);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_clr_rise) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef COCO_REGCAP_HALT_EN
    localparam logic [PTR_W:0] C_AFULL = (PTR_W+1)'(DEPTH-1);

    logic r_halt;

    // One spare slot absorbs the write already in flight when the halt lands.
    always_ff @(posedge eclk) begin
        if (!reset_n) begin
            r_halt <= 1'b0;
        end else begin
            r_halt <= (w_count_nx >= C_AFULL);
        end
    end

    assign halt_req = r_halt;
`else
    assign halt_req = 1'b0;
`endif

    assign a_reg_addr = r_head.addr;
    assign a_reg_data = r_head.data;
    assign a_empty    = r_empty;
    assign a_full     = r_full;
    assign a_regint   = ~r_empty;
    assign a_ovf      = r_ovf;

endmodule

// File: tb/tb_coco_regcap_fifo.sv
// Directed scoreboard bench for coco_regcap_fifo.
// Honors COCO_REGCAP_HALT_EN for the expected halt_req.
module tb_coco_regcap_fifo;

    localparam int DEPTH = 4;

    logic       eclk = 1'b0;
    logic       reset_n;
    logic       c_power;
    logic       scs_n;
    logic       c_rw;
    logic [3:0] c_addr;
    logic [7:0] c_data;
    logic       a_busmaster;
    logic       a_pop;
    logic       a_clr_ovf;
    logic [3:0] a_reg_addr;
    logic [7:0] a_reg_data;
    logic       a_empty;
    logic       a_full;
    logic       a_regint;
    logic       a_ovf;
    logic       halt_req;

    int         total = 0;
    int         bad   = 0;
    logic       exp_ovf = 1'b0;
    logic [11:0] q[$];

    coco_regcap_fifo #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .eclk        (eclk),
        .reset_n     (reset_n),
        .c_power     (c_power),
        .scs_n       (scs_n),
        .c_rw        (c_rw),
        .c_addr      (c_addr),
        .c_data      (c_data),
        .a_busmaster (a_busmaster),
        .a_pop       (a_pop),
        .a_clr_ovf   (a_clr_ovf),
        .a_reg_addr  (a_reg_addr),
        .a_reg_data  (a_reg_data),
        .a_empty     (a_empty),
        .a_full      (a_full),
        .a_regint    (a_regint),
        .a_ovf       (a_ovf),
        .halt_req    (halt_req)
    );

    always #5 eclk = ~eclk;

    task automatic tick();
        @(posedge eclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        logic exp_halt;
        int   n;
        n = q.size();
`ifdef COCO_REGCAP_HALT_EN
        exp_halt = (n >= DEPTH - 1);
`else
        exp_halt = 1'b0;
`endif
        check({tag, ".empty"},  32'(a_empty),  32'(n == 0));
        check({tag, ".full"},   32'(a_full),   32'(n == DEPTH));
        check({tag, ".regint"}, 32'(a_regint), 32'(n != 0));
        check({tag, ".ovf"},    32'(a_ovf),    32'(exp_ovf));
        check({tag, ".halt"},   32'(halt_req), 32'(exp_halt));
    endtask

    task automatic check_head(input string tag);
        if (q.size() != 0) begin
            check({tag, ".head"}, 32'({a_reg_addr, a_reg_data}), 32'(q[0]));
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d,
                             input logic rw, input logic busm,
                             input logic pwr);
        scs_n       = 1'b0;
        c_rw        = rw;
        a_busmaster = busm;
        c_power     = pwr;
        c_addr      = a;
        c_data      = d;
        if (!rw && !busm && pwr) begin
            if (q.size() < DEPTH) q.push_back({a, d});
            else exp_ovf = 1'b1;
        end
        tick();
        scs_n       = 1'b1;
        c_rw        = 1'b1;
        a_busmaster = 1'b0;
        c_power     = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus_write(a, d, 1'b0, 1'b0, 1'b1);
    endtask

    // Compares the head against the scoreboard, then pops it.
    task automatic avr_pop(input string tag);
        check_head(tag);
        if (q.size() != 0) void'(q.pop_front());
        a_pop = 1'b1;
        tick();
        a_pop = 1'b0;
        tick();
        tick();
    endtask

    // The synchronized pop lands on the same edge as this write.
    task automatic pop_push(input string tag, input logic [3:0] a,
                            input logic [7:0] d);
        check_head(tag);
        void'(q.pop_front());
        q.push_back({a, d});
        a_pop = 1'b1;
        tick();
        a_pop = 1'b0;
        tick();
        scs_n  = 1'b0;
        c_rw   = 1'b0;
        c_addr = a;
        c_data = d;
        tick();
        scs_n  = 1'b1;
        c_rw   = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        c_power     = 1'b1;
        scs_n       = 1'b1;
        c_rw        = 1'b1;
        c_addr      = '0;
        c_data      = '0;
        a_busmaster = 1'b0;
        a_pop       = 1'b0;
        a_clr_ovf   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check_flags("reset");
        check("reset.head", 32'({a_reg_addr, a_reg_data}), 32'h0);

        wr(4'h8, 8'hA5);
        check_flags("single");
        check("single.addr", 32'(a_reg_addr), 32'h8);
        check("single.data", 32'(a_reg_data), 32'hA5);
        avr_pop("single");
        check_flags("single_pop");

        wr(4'h0, 8'h11);
        wr(4'h1, 8'h22);
        check_flags("order2");
        wr(4'h2, 8'h33);
        check_flags("order3");
        wr(4'h3, 8'h44);
        check_flags("order_full");
        for (int i = 0; i < 4; i++) begin
            avr_pop("order");
            check_flags("order_pop");
        end

        wr(4'h0, 8'h11);
        wr(4'h1, 8'h22);
        wr(4'h2, 8'h33);
        wr(4'h3, 8'h44);
        wr(4'h5, 8'h55);
        check_flags("ovf");
        check("ovf.head", 32'(a_reg_data), 32'h11);
        for (int i = 0; i < 4; i++) avr_pop("ovf_drain");
        check_flags("ovf_drained");
        a_clr_ovf = 1'b1;
        tick();
        a_clr_ovf = 1'b0;
        tick();
        tick();
        exp_ovf = 1'b0;
        check_flags("ovf_clr");

        wr(4'h6, 8'h61);
        wr(4'h7, 8'h72);
        pop_push("pp2", 4'h8, 8'h83);
        check_flags("pp2");
        check_head("pp2_adv");
        wr(4'h9, 8'h94);
        wr(4'hA, 8'hA5);
        check_flags("pp_fill");
        pop_push("ppfull", 4'hB, 8'hB6);
        check_flags("ppfull");
        check_head("ppfull_adv");
        while (q.size() != 0) avr_pop("pp_drain");
        check_flags("pp_drained");

        bus_write(4'h1, 8'h01, 1'b0, 1'b1, 1'b1);
        check_flags("gate_busm");
        bus_write(4'h2, 8'h02, 1'b0, 1'b0, 1'b0);
        check_flags("gate_pwr");
        bus_write(4'h3, 8'h03, 1'b1, 1'b0, 1'b1);
        check_flags("gate_read");
        avr_pop("empty_pop");
        check_flags("empty_pop");
        wr(4'h7, 8'h77);
        check_flags("after_empty_pop");
        check_head("after_empty_pop");
        avr_pop("after_empty_pop");
        check_flags("after_empty_pop2");

        wr(4'h1, 8'hC1);
        wr(4'h2, 8'hC2);
        wr(4'h3, 8'hC3);
        check_flags("midfill");
        reset_n = 1'b0;
        tick();
        q.delete();
        exp_ovf = 1'b0;
        check_flags("midreset");
        reset_n = 1'b1;
        wr(4'h4, 8'hD4);
        check_flags("post_reset");
        check_head("post_reset");
        avr_pop("post_reset");
        check_flags("post_reset_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coco_regcap_fifo.md
Name: coco_regcap_fifo

Overview:
- Sits between the CoCo cartridge bus and the AVR, alongside the bus-arbitration block that owns the shared SRAM/EEPROM path.
- Captures every CoCo write to the SCS register window (4-bit offset + 8-bit data) into a small FIFO.
- Raises a level interrupt to the AVR while the FIFO holds entries; the AVR drains entries one at a time with a pop strobe.
- Replaces the single-bit "register written" flag with ordered, lossless-until-full command delivery for FDC register emulation.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..8.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- eclk  input  1  CoCo E clock; sole clock, all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- c_power  input  1  1 = CoCo powered; captures are gated off when 0.
- scs_n  input  1  0 = CoCo register-window select.
- c_rw  input  1  CoCo read/write; 0 = write.
- c_addr  input  4  CoCo address bits [3:0], the register offset.
- c_data  input  8  CoCo data bus, input-only view.
- a_busmaster  input  1  1 = AVR owns the memory bus; captures are gated off.
- a_pop  input  1  AVR pop request; asynchronous level, one toggle-high per pop.
- a_clr_ovf  input  1  AVR overflow clear; asynchronous level.
- a_reg_addr  output  4  offset of the head entry.
- a_reg_data  output  8  data of the head entry.
- a_empty  output  1  1 = FIFO empty.
- a_full  output  1  1 = FIFO full.
- a_regint  output  1  AVR interrupt; 1 while not empty.
- a_ovf  output  1  sticky: a write was dropped.
- halt_req  output  1  halt request toward the arbitration block; only functional with the optional feature.

Behaviour:
- Reset (reset_n low at posedge eclk):
  - read pointer, write pointer and count cleared to 0.
  - a_empty = 1, a_full = 0, a_regint = 0, a_ovf = 0, halt_req = 0.
  - a_reg_addr and a_reg_data = 0; sync flops cleared.
  - A reset mid-operation discards all entries; there is no partial state.
- Push condition, sampled at posedge eclk: `push = ~scs_n & ~c_rw & c_power & ~a_busmaster`.
  - Exactly one push per E cycle, because each E rising edge is one bus cycle.
  - Entry stored = {c_addr, c_data}, a 12-bit entry.
- Pop path:
  - a_pop passes through a 2-flop synchronizer, then a rising-edge detector.
  - `pop = edge & ~empty`.
  - A pop while empty is ignored; it does not underflow or corrupt the pointers.
- Pointers:
  - Each pointer increments mod DEPTH; wrap-around is natural.
  - count is PTR_W+1 bits wide.
- Push and pop in the same cycle:
  - Not full: both happen, count unchanged.
  - Full: both happen; the push is accepted and a_ovf is not set.
- Push while full with no pop: the entry is dropped, a_ovf is set to 1, and pointers are unchanged.
- a_ovf clear:
  - Cleared on the synchronized rising edge of a_clr_ovf.
  - If a drop occurs in the same cycle, set wins.
- Head outputs:
  - a_reg_addr and a_reg_data are registered copies of mem[rd_ptr], updated the cycle after any push-to-empty or pop.
  - Push-to-visible latency: the entry appears on the outputs and a_regint rises 1 eclk after the capturing edge.
  - AVR pop latency: 2 sync cycles + 1 cycle.
- Flag timing: a_empty, a_full and a_regint are registered from next-state count; no combinational paths from inputs.
- CoCo reads (c_rw = 1) of the window are not captured.

Optional Feature:
- Macro: COCO_REGCAP_HALT_EN.
- Defined:
  - halt_req is registered 1 when next count >= DEPTH-1 (almost full), and 0 otherwise.
  - The arbitration block halts the CoCo on halt_req; the one spare slot absorbs the write in flight during halt latency.
  - a_ovf still operates.
- Undefined: halt_req is tied to 0; overflow drops as above.

Decomposition:
- Package coco_regcap_pkg holds:
  - ENTRY_W = 12, ADDR_LSB = 8, DATA_LSB = 0.
  - The entry typedef {addr[3:0], data[7:0]}.
  - Default DEPTH.
- Sub-module coco_pulse_sync: 2-flop synchronizer plus rising-edge detect.
  - Instantiated twice, for a_pop and a_clr_ovf.
  - Shares eclk and reset_n.
- FIFO storage and pointers stay in the top module.

Test Plan:
- Reset then a single write: scs_n = 0, c_rw = 0, c_addr = 4'h8, c_data = 8'hA5.
  - 1 eclk later: a_regint = 1, a_empty = 0, a_reg_addr = 8, a_reg_data = A5.
  - After a_pop pulse plus 3 eclk: a_empty = 1, a_regint = 0.
- Ordering: writes {0,11}, {1,22}, {2,33}, {3,44}.
  - a_full = 1.
  - Four pops yield 11, 22, 33, 44 in order, then a_empty = 1.
- Overflow: a fifth write {5,55} while full.
  - a_ovf = 1; head still 11.
  - Drain yields only 4 entries.
  - a_clr_ovf pulse clears a_ovf.
- Simultaneous push and pop with count = 2: count stays 2 and the head advances.
  - Repeat at full: the push is accepted and a_ovf stays 0.
- Gating: writes with a_busmaster = 1, c_power = 0, or c_rw = 1 leave a_empty = 1.
  - A pop while empty leaves the pointers at 0.
  - reset_n low mid-fill with 3 entries gives a_empty = 1 the next cycle.
- Feature COCO_REGCAP_HALT_EN defined:
  - halt_req rises on the capture that makes count = 3.
  - halt_req falls on the pop that makes count = 2.
  - Undefined: halt_req stays 0 throughout.
